// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op encoding, DMI response codes and arbiter states.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'h0,
        ARB_ISSUE  = 2'h1,
        ARB_WAIT   = 2'h2,
        ARB_RETURN = 2'h3
    } arb_state_e;

endpackage

// File: rtl/dmi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping around.
module dmi_rr_arbiter #(
    parameter int unsigned NUM_HOSTS = 2,
    localparam int unsigned OW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic [NUM_HOSTS-1:0] req_i,
    input  logic [OW-1:0]        ptr_i,
    output logic [OW-1:0]        idx_o,
    output logic                 valid_o
);

    localparam int unsigned SW = OW + 1;

    logic [2*NUM_HOSTS-1:0] dbl;
    logic [NUM_HOSTS-1:0]   rot;
    logic [SW-1:0]          sum;
    logic                   found;

    // rot[k] is the request of host (ptr_i + k) mod NUM_HOSTS
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NUM_HOSTS-1:0];

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_i} + SW'(k);
                if (sum >= SW'(NUM_HOSTS)) begin
                    sum = sum - SW'(NUM_HOSTS);
                end
                idx_o = sum[OW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/dmi_host_arbiter.sv
// Round-robin DMI arbiter: one transaction in flight, responses routed to the issuer,
// local NOP answers and a watchdog that fails and clears a stalled DM transaction.
module dmi_host_arbiter
    import dm::*;
#(
    parameter int unsigned NUM_HOSTS      = 2,
    parameter int unsigned ABITS          = 7,
    parameter int unsigned DBITS          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned OW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic [NUM_HOSTS-1:0]       host_req_valid_i,
    output logic [NUM_HOSTS-1:0]       host_req_ready_o,
    input  logic [NUM_HOSTS*ABITS-1:0] host_req_addr_i,
    input  logic [NUM_HOSTS*DBITS-1:0] host_req_data_i,
    input  logic [NUM_HOSTS*2-1:0]     host_req_op_i,
    output logic [NUM_HOSTS-1:0]       host_resp_valid_o,
    input  logic [NUM_HOSTS-1:0]       host_resp_ready_i,
    output logic [DBITS-1:0]           host_resp_data_o,
    output logic [1:0]                 host_resp_resp_o,
    input  logic [NUM_HOSTS-1:0]       host_clear_i,
    output logic                       dmi_req_valid_o,
    input  logic                       dmi_req_ready_i,
    output logic [ABITS-1:0]           dmi_req_addr_o,
    output logic [DBITS-1:0]           dmi_req_data_o,
    output logic [1:0]                 dmi_req_op_o,
    input  logic                       dmi_resp_valid_i,
    output logic                       dmi_resp_ready_o,
    input  logic [DBITS-1:0]           dmi_resp_data_i,
    input  logic [1:0]                 dmi_resp_resp_i,
    output logic                       dmi_clear_o,
    output logic [OW-1:0]              owner_o,
    output logic                       busy_o
);

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [ABITS-1:0]  addr_q, addr_d;
    logic [DBITS-1:0]  data_q, data_d;
    dtm_op_e           op_q, op_d;
    logic [DBITS-1:0]  rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              clear_q, clear_d;

    logic [OW-1:0]     win_idx;
    logic              win_valid;
    logic [ABITS-1:0]  win_addr;
    logic [DBITS-1:0]  win_data;
    dtm_op_e           win_op;
    logic              owner_clr_c;
    logic              owner_rdy_c;
    logic              timeout_c;
    logic [OW-1:0]     ptr_next_c;

    dmi_rr_arbiter #(.NUM_HOSTS(NUM_HOSTS)) u_rr (
        .req_i   (host_req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Per-host muxing with constant selects
    always_comb begin
        win_addr    = '0;
        win_data    = '0;
        win_op      = DTM_NOP;
        owner_clr_c = 1'b0;
        owner_rdy_c = 1'b0;
        for (int unsigned h = 0; h < NUM_HOSTS; h++) begin
            if (win_idx == OW'(h)) begin
                win_addr = host_req_addr_i[h*ABITS +: ABITS];
                win_data = host_req_data_i[h*DBITS +: DBITS];
                win_op   = dtm_op_e'(host_req_op_i[h*2 +: 2]);
            end
            if (owner_q == OW'(h)) begin
                owner_clr_c = host_clear_i[h];
                owner_rdy_c = host_resp_ready_i[h];
            end
        end
    end

    assign ptr_next_c = (owner_q == OW'(NUM_HOSTS - 1)) ? '0 : owner_q + OW'(1);

    // Watchdog is zero outside ISSUE/WAIT, so it restarts on every ISSUE entry
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
        logic [WW-1:0] wdog_q, wdog_d;
        logic          counting;

        assign counting  = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
        assign timeout_c = counting && (wdog_q == WW'(TIMEOUT_CYCLES - 1));

        always_comb begin
            wdog_d = '0;
            if (counting) begin
                wdog_d = wdog_q + WW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_d;
            end
        end
    end else begin : g_no_wdog
        assign timeout_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= DTM_NOP;
            rdata_q <= '0;
            rresp_q <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            clear_q <= clear_d;
        end
    end

    // Owner clear beats everything; a DM response beats a same-cycle timeout
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        ptr_d            = ptr_q;
        addr_d           = addr_q;
        data_d           = data_q;
        op_d             = op_q;
        rdata_d          = rdata_q;
        rresp_d          = rresp_q;
        clear_d          = 1'b0;
        host_req_ready_o = '0;
        case (state_q)
            ARB_IDLE: begin
                clear_d = |host_clear_i;
                if (win_valid) begin
                    for (int unsigned h = 0; h < NUM_HOSTS; h++) begin
                        host_req_ready_o[h] = (win_idx == OW'(h)) && !rst_i;
                    end
                    owner_d = win_idx;
                    addr_d  = win_addr;
                    data_d  = win_data;
                    op_d    = win_op;
                    if (win_op == DTM_NOP) begin
                        rdata_d = '0;
                        rresp_d = DTM_SUCCESS;
                        state_d = ARB_RETURN;
                    end else begin
                        state_d = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                if (owner_clr_c) begin
                    clear_d = 1'b1;
                    ptr_d   = ptr_next_c;
                    state_d = ARB_IDLE;
                end else if (timeout_c) begin
                    clear_d = 1'b1;
                    rdata_d = '0;
                    rresp_d = DTM_ERR;
                    state_d = ARB_RETURN;
                end else if (dmi_req_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (owner_clr_c) begin
                    clear_d = 1'b1;
                    ptr_d   = ptr_next_c;
                    state_d = ARB_IDLE;
                end else if (dmi_resp_valid_i) begin
                    rdata_d = dmi_resp_data_i;
                    rresp_d = dmi_resp_resp_i;
                    state_d = ARB_RETURN;
                end else if (timeout_c) begin
                    clear_d = 1'b1;
                    rdata_d = '0;
                    rresp_d = DTM_ERR;
                    state_d = ARB_RETURN;
                end
            end
            ARB_RETURN: begin
                if (owner_clr_c) begin
                    clear_d = 1'b1;
                    ptr_d   = ptr_next_c;
                    state_d = ARB_IDLE;
                end else if (owner_rdy_c) begin
                    ptr_d   = ptr_next_c;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        host_resp_valid_o = '0;
        for (int unsigned h = 0; h < NUM_HOSTS; h++) begin
            host_resp_valid_o[h] = (state_q == ARB_RETURN) && (owner_q == OW'(h));
        end
    end

    assign dmi_req_valid_o  = (state_q == ARB_ISSUE);
    assign dmi_resp_ready_o = (state_q == ARB_WAIT);
    assign busy_o           = (state_q != ARB_IDLE);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = op_q;
    assign host_resp_data_o = rdata_q;
    assign host_resp_resp_o = rresp_q;
    assign dmi_clear_o      = clear_q;
    assign owner_o          = owner_q;

endmodule

// File: tb/tb_dmi_host_arbiter.sv
// Directed bench for dmi_host_arbiter: two hosts, 16-cycle watchdog.
module tb_dmi_host_arbiter;

    localparam int unsigned NH = 2;
    localparam int unsigned AB = 7;
    localparam int unsigned DB = 32;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NH-1:0]  host_req_valid_i;
    logic [NH-1:0]  host_req_ready_o;
    logic [NH*AB-1:0] host_req_addr_i;
    logic [NH*DB-1:0] host_req_data_i;
    logic [NH*2-1:0]  host_req_op_i;
    logic [NH-1:0]  host_resp_valid_o;
    logic [NH-1:0]  host_resp_ready_i;
    logic [DB-1:0]  host_resp_data_o;
    logic [1:0]     host_resp_resp_o;
    logic [NH-1:0]  host_clear_i;
    logic           dmi_req_valid_o;
    logic           dmi_req_ready_i;
    logic [AB-1:0]  dmi_req_addr_o;
    logic [DB-1:0]  dmi_req_data_o;
    logic [1:0]     dmi_req_op_o;
    logic           dmi_resp_valid_i;
    logic           dmi_resp_ready_o;
    logic [DB-1:0]  dmi_resp_data_i;
    logic [1:0]     dmi_resp_resp_i;
    logic           dmi_clear_o;
    logic [0:0]     owner_o;
    logic           busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmi_host_arbiter #(
        .NUM_HOSTS(NH), .ABITS(AB), .DBITS(DB), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .host_req_valid_i  (host_req_valid_i),
        .host_req_ready_o  (host_req_ready_o),
        .host_req_addr_i   (host_req_addr_i),
        .host_req_data_i   (host_req_data_i),
        .host_req_op_i     (host_req_op_i),
        .host_resp_valid_o (host_resp_valid_o),
        .host_resp_ready_i (host_resp_ready_i),
        .host_resp_data_o  (host_resp_data_o),
        .host_resp_resp_o  (host_resp_resp_o),
        .host_clear_i      (host_clear_i),
        .dmi_req_valid_o   (dmi_req_valid_o),
        .dmi_req_ready_i   (dmi_req_ready_i),
        .dmi_req_addr_o    (dmi_req_addr_o),
        .dmi_req_data_o    (dmi_req_data_o),
        .dmi_req_op_o      (dmi_req_op_o),
        .dmi_resp_valid_i  (dmi_resp_valid_i),
        .dmi_resp_ready_o  (dmi_resp_ready_o),
        .dmi_resp_data_i   (dmi_resp_data_i),
        .dmi_resp_resp_i   (dmi_resp_resp_i),
        .dmi_clear_o       (dmi_clear_o),
        .owner_o           (owner_o),
        .busy_o            (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  grants;
        int  resps;
        int  last_g;
        int  n;
        logic seen;
        logic drop;

        rst_i             = 1'b1;
        host_req_valid_i  = '0;
        host_req_addr_i   = '0;
        host_req_data_i   = '0;
        host_req_op_i     = '0;
        host_resp_ready_i = '0;
        host_clear_i      = '0;
        dmi_req_ready_i   = 1'b0;
        dmi_resp_valid_i  = 1'b0;
        dmi_resp_data_i   = '0;
        dmi_resp_resp_i   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_dmi_req_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("rst_host_resp_valid", 64'(host_resp_valid_o), 64'd0);
        chk("rst_dmi_clear", 64'(dmi_clear_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // 1: host0 WRITE 0x10, DM ready, response the cycle after the request handshake
        host_req_valid_i = 2'b01;
        host_req_addr_i  = {7'h00, 7'h10};
        host_req_data_i  = {32'h0, 32'h07FF_FFC1};
        host_req_op_i    = {2'd0, 2'd2};
        dmi_req_ready_i  = 1'b1;
        dmi_resp_data_i  = 32'h1234_5678;
        dmi_resp_resp_i  = 2'd0;
        #1 chk("t1_req_ready", 64'(host_req_ready_o), 64'h1);
        @(negedge clk);
        host_req_valid_i = '0;
        chk("t1_dm_valid", 64'(dmi_req_valid_o), 64'd1);
        chk("t1_dm_op", 64'(dmi_req_op_o), 64'd2);
        chk("t1_dm_addr", 64'(dmi_req_addr_o), 64'h10);
        chk("t1_dm_data", 64'(dmi_req_data_o), 64'h07FF_FFC1);
        chk("t1_owner", 64'(owner_o), 64'd0);
        chk("t1_no_resp_c1", 64'(host_resp_valid_o), 64'd0);
        @(negedge clk);
        chk("t1_dm_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        chk("t1_no_resp_c2", 64'(host_resp_valid_o), 64'd0);
        dmi_resp_valid_i = 1'b1;
        @(negedge clk);
        dmi_resp_valid_i = 1'b0;
        chk("t1_resp_valid", 64'(host_resp_valid_o), 64'h1);
        chk("t1_resp_code", 64'(host_resp_resp_o), 64'd0);
        chk("t1_resp_data", 64'(host_resp_data_o), 64'h1234_5678);
        host_resp_ready_i = 2'b01;
        @(negedge clk);
        host_resp_ready_i = '0;
        chk("t1_idle", 64'(busy_o), 64'd0);

        // 3: host1 NOP answered locally (rr pointer now at host1)
        host_req_valid_i = 2'b10;
        host_req_op_i    = {2'd0, 2'd0};
        dmi_resp_data_i  = 32'hDEAD_BEEF;
        #1 chk("t3_req_ready", 64'(host_req_ready_o), 64'h2);
        @(negedge clk);
        host_req_valid_i = '0;
        chk("t3_resp_valid", 64'(host_resp_valid_o), 64'h2);
        chk("t3_resp_data", 64'(host_resp_data_o), 64'd0);
        chk("t3_resp_code", 64'(host_resp_resp_o), 64'd0);
        chk("t3_no_dm_req", 64'(dmi_req_valid_o), 64'd0);
        host_resp_ready_i = 2'b10;
        @(negedge clk);
        host_resp_ready_i = '0;
        chk("t3_idle", 64'(busy_o), 64'd0);

        // 2: both hosts READ 0x11 continuously; grants alternate starting at host0
        host_req_valid_i  = 2'b11;
        host_req_addr_i   = {7'h11, 7'h11};
        host_req_op_i     = {2'd1, 2'd1};
        host_resp_ready_i = 2'b11;
        dmi_resp_data_i   = 32'hCAFE_BABE;
        grants = 0;
        resps  = 0;
        last_g = 0;
        drop   = 1'b0;
        for (int c = 0; c < 40 && resps < 4; c++) begin
            #1;
            if (drop) host_req_valid_i = '0;
            if (host_req_ready_o != '0) begin
                chk("t2_grant", 64'(host_req_ready_o), (grants % 2 == 0) ? 64'h1 : 64'h2);
                last_g = host_req_ready_o[1] ? 1 : 0;
                grants++;
                if (grants == 4) drop = 1'b1;
            end
            if (host_resp_valid_o != '0) begin
                chk("t2_resp_route", 64'(host_resp_valid_o), (last_g == 1) ? 64'h2 : 64'h1);
                chk("t2_resp_data", 64'(host_resp_data_o), 64'hCAFE_BABE);
                resps++;
            end
            dmi_resp_valid_i = dmi_resp_ready_o;
            @(negedge clk);
        end
        chk("t2_grants", 64'(grants), 64'd4);
        chk("t2_resps", 64'(resps), 64'd4);
        host_req_valid_i  = '0;
        host_resp_ready_i = '0;
        dmi_resp_valid_i  = 1'b0;

        // 4: DM accepts but never responds; watchdog fires after 16 ISSUE/WAIT cycles
        host_req_valid_i = 2'b01;
        host_req_addr_i  = {7'h00, 7'h05};
        dmi_resp_data_i  = 32'hBAD0_BAD0;
        #1 chk("t4_req_ready", 64'(host_req_ready_o), 64'h1);
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            host_req_valid_i = '0;
            if (dmi_clear_o) seen = 1'b1;
            else if (busy_o && host_resp_valid_o == '0) n++;
        end
        chk("t4_clear_seen", 64'(seen), 64'd1);
        chk("t4_cycles", 64'(n), 64'd16);
        chk("t4_resp_valid", 64'(host_resp_valid_o), 64'h1);
        chk("t4_resp_code", 64'(host_resp_resp_o), 64'd2);
        chk("t4_resp_data", 64'(host_resp_data_o), 64'd0);
        host_resp_ready_i = 2'b01;
        @(negedge clk);
        host_resp_ready_i = '0;
        chk("t4_clear_once", 64'(dmi_clear_o), 64'd0);
        chk("t4_idle", 64'(busy_o), 64'd0);
        host_req_valid_i = 2'b10;
        #1 chk("t4_next_grant", 64'(host_req_ready_o), 64'h2);
        @(negedge clk);
        host_req_valid_i = '0;
        @(negedge clk);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'h0000_55AA;
        @(negedge clk);
        dmi_resp_valid_i = 1'b0;
        chk("t4_next_resp", 64'(host_resp_valid_o), 64'h2);
        chk("t4_next_data", 64'(host_resp_data_o), 64'h55AA);
        host_resp_ready_i = 2'b10;
        @(negedge clk);
        host_resp_ready_i = '0;

        // 5: owner clear and DM response in the same WAIT cycle; clear wins
        host_req_valid_i = 2'b01;
        #1 chk("t5_grant", 64'(host_req_ready_o), 64'h1);
        @(negedge clk);
        host_req_valid_i = '0;
        @(negedge clk);
        chk("t5_in_wait", 64'(dmi_resp_ready_o), 64'd1);
        host_clear_i     = 2'b01;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'h1111_2222;
        @(negedge clk);
        host_clear_i     = '0;
        dmi_resp_valid_i = 1'b0;
        chk("t5_clear", 64'(dmi_clear_o), 64'd1);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_no_resp", 64'(host_resp_valid_o), 64'd0);
        @(negedge clk);
        chk("t5_clear_pulse", 64'(dmi_clear_o), 64'd0);
        chk("t5_no_resp_late", 64'(host_resp_valid_o), 64'd0);

        // Clear in IDLE is forwarded to the DM
        host_clear_i = 2'b10;
        @(negedge clk);
        host_clear_i = '0;
        chk("t5_idle_clear", 64'(dmi_clear_o), 64'd1);
        @(negedge clk);

        // 6: host1 in WAIT, non-owner clear ignored, then reset mid-WAIT
        host_req_valid_i = 2'b10;
        #1 chk("t6_grant", 64'(host_req_ready_o), 64'h2);
        @(negedge clk);
        host_req_valid_i = '0;
        @(negedge clk);
        chk("t6_wait", 64'(dmi_resp_ready_o), 64'd1);
        host_clear_i = 2'b01;
        @(negedge clk);
        host_clear_i = '0;
        chk("t6_nonowner_clear", 64'(dmi_clear_o), 64'd0);
        chk("t6_still_busy", 64'(busy_o), 64'd1);
        chk("t6_owner", 64'(owner_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("t6_rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("t6_rst_host_resp", 64'(host_resp_valid_o), 64'd0);
        chk("t6_rst_owner", 64'(owner_o), 64'd0);
        chk("t6_rst_addr", 64'(dmi_req_addr_o), 64'd0);
        chk("t6_rst_req_ready", 64'(host_req_ready_o), 64'd0);
        @(negedge clk);
        rst_i            = 1'b0;
        host_req_valid_i = 2'b11;
        #1 chk("t6_first_grant", 64'(host_req_ready_o), 64'h1);
        @(negedge clk);
        host_req_valid_i = '0;
        chk("t6_first_owner", 64'(owner_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
